ped_request_ctrl: RTL and testbench

//   Pedestrian-button front end for the traffic_light controller. Synchronises
//   and debounces a raw push-button, latches one crossing request, and drives

---
 rtl/ped_request_ctrl_if.sv | 22 ++
 rtl/ped_request_ctrl.sv | 108 ++++++++++
 tb/tb_ped_request_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ped_request_ctrl_if.sv
// Pedestrian request bus between the button front end and its environment:
// button/lamp/countdown inputs plus the request/indicator outputs.
interface ped_request_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             btn_raw;
  logic             green;
  logic [CNT_W-1:0] clock;
  logic             pass_request;
  logic             wait_led;
  logic             served;

  modport master (
    output btn_raw, green, clock,
    input  pass_request, wait_led, served
  );

  modport slave (
    input  btn_raw, green, clock,
    output pass_request, wait_led, served
  );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian-button front end: synchronise, debounce, latch one request and
// hand it to the light controller while enough green time remains.
module ped_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GRANT_THRESH    = 10,
  parameter int COOLDOWN_CYCLES = 32,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  ped_request_ctrl_if.slave ped_if
);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CD_W-1:0]  CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(GRANT_THRESH);

  typedef enum logic [1:0] {IDLE, PENDING, SERVING, COOLDOWN} state_t;

  logic            sync1_q, sync2_q;
  logic            level_q;
  logic            press_q;
  logic [DB_W-1:0] db_cnt_q;

  state_t          state_q, state_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            served_q, served_d;
  logic            pass_q;
  logic            wait_q;
  logic            above_thresh;

  assign above_thresh = (ped_if.clock > THRESH);

  // press_q is registered on the same edge the level rises, so it strobes
  // exactly while the new high level is first visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      level_q  <= 1'b0;
      press_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q <= ped_if.btn_raw;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_q  <= sync2_q;
        db_cnt_q <= '0;
        press_q  <= sync2_q;
      end else begin
        db_cnt_q <= db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    served_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_q) state_d = PENDING;
      end
      PENDING: begin
        if (ped_if.green && !above_thresh) begin
          state_d  = SERVING;
          served_d = 1'b1;
        end
      end
      SERVING: begin
        if (!ped_if.green) begin
          state_d = COOLDOWN;
          cd_d    = CD_LAST;
        end
      end
      COOLDOWN: begin
        // Presses here are simply not looked at, so none carry over to IDLE.
        if (cd_q == '0) state_d = IDLE;
        else            cd_d    = cd_q - CD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cd_q     <= '0;
      served_q <= 1'b0;
      pass_q   <= 1'b0;
      wait_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cd_q     <= cd_d;
      served_q <= served_d;
      pass_q   <= (state_q == PENDING) && ped_if.green && above_thresh;
      wait_q   <= (state_d == PENDING) || (state_d == SERVING);
    end
  end

  assign ped_if.pass_request = pass_q;
  assign ped_if.wait_led     = wait_q;
  assign ped_if.served       = served_q;
endmodule

// File: tb/tb_ped_request_ctrl.sv
// Directed bench for ped_request_ctrl: debounce latency, bounce rejection,
// grant/serve handshake, cooldown masking and asynchronous reset.
module tb_ped_request_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic any_pass, any_wait;

  ped_request_ctrl_if #(.CNT_W(8)) ped_if ();

  ped_request_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .GRANT_THRESH   (10),
    .COOLDOWN_CYCLES(32),
    .CNT_W          (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ped_if(ped_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst            = 1'b1;
    ped_if.btn_raw = 1'b0;
    ped_if.green   = 1'b0;
    ped_if.clock   = 8'd0;
    tick(2);
    check("rst_pass", 32'(ped_if.pass_request), 32'd0);
    check("rst_wait", 32'(ped_if.wait_led), 32'd0);
    check("rst_served", 32'(ped_if.served), 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: clean press on green with plenty of time left
    ped_if.green   = 1'b1;
    ped_if.clock   = 8'd50;
    ped_if.btn_raw = 1'b1;
    tick(18);
    check("t1_wait_before", 32'(ped_if.wait_led), 32'd0);
    tick(1);
    check("t1_wait_pending", 32'(ped_if.wait_led), 32'd1);
    check("t1_pass_lag", 32'(ped_if.pass_request), 32'd0);
    tick(1);
    check("t1_pass", 32'(ped_if.pass_request), 32'd1);
    check("t1_served", 32'(ped_if.served), 32'd0);
    tick(20);
    ped_if.btn_raw = 1'b0;
    tick(25);
    check("t1_pass_held", 32'(ped_if.pass_request), 32'd1);
    check("t1_wait_held", 32'(ped_if.wait_led), 32'd1);

    // 2: bouncing button never settles long enough
    do_reset();
    any_pass = 1'b0;
    any_wait = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ped_if.btn_raw = ~ped_if.btn_raw;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        any_pass |= ped_if.pass_request;
        any_wait |= ped_if.wait_led;
      end
    end
    for (int j = 0; j < 30; j++) begin
      tick(1);
      any_pass |= ped_if.pass_request;
      any_wait |= ped_if.wait_led;
    end
    check("t2_no_pass", 32'(any_pass), 32'd0);
    check("t2_no_wait", 32'(any_wait), 32'd0);

    // 3: press during red, grant once green, serve as time runs low
    do_reset();
    ped_if.green   = 1'b0;
    ped_if.clock   = 8'd60;
    ped_if.btn_raw = 1'b1;
    tick(40);
    ped_if.btn_raw = 1'b0;
    check("t3_wait_red", 32'(ped_if.wait_led), 32'd1);
    check("t3_pass_red", 32'(ped_if.pass_request), 32'd0);
    tick(25);
    check("t3_pass_still_red", 32'(ped_if.pass_request), 32'd0);
    ped_if.green = 1'b1;
    tick(1);
    check("t3_pass_green", 32'(ped_if.pass_request), 32'd1);
    ped_if.clock = 8'd10;
    tick(1);
    check("t3_served", 32'(ped_if.served), 32'd1);
    check("t3_pass_drop", 32'(ped_if.pass_request), 32'd0);
    check("t3_wait_serving", 32'(ped_if.wait_led), 32'd1);
    tick(1);
    check("t3_served_pulse", 32'(ped_if.served), 32'd0);
    check("t3_wait_serving2", 32'(ped_if.wait_led), 32'd1);

    // 4: green ends -> cooldown; a press inside it is forgotten
    ped_if.green = 1'b0;
    tick(1);
    check("t4_wait_cooldown", 32'(ped_if.wait_led), 32'd0);
    tick(4);
    ped_if.btn_raw = 1'b1;
    tick(40);
    check("t4_press_ignored", 32'(ped_if.wait_led), 32'd0);
    ped_if.btn_raw = 1'b0;
    tick(25);
    check("t4_still_idle", 32'(ped_if.wait_led), 32'd0);
    ped_if.btn_raw = 1'b1;
    tick(18);
    check("t4_repress_before", 32'(ped_if.wait_led), 32'd0);
    tick(1);
    check("t4_repress_pending", 32'(ped_if.wait_led), 32'd1);
    ped_if.btn_raw = 1'b0;
    tick(25);

    // 5: press when green is already below threshold
    do_reset();
    ped_if.green   = 1'b1;
    ped_if.clock   = 8'd8;
    ped_if.btn_raw = 1'b1;
    any_pass       = 1'b0;
    for (int j = 0; j < 19; j++) begin
      tick(1);
      any_pass |= ped_if.pass_request;
    end
    check("t5_wait_pending", 32'(ped_if.wait_led), 32'd1);
    check("t5_served_early", 32'(ped_if.served), 32'd0);
    tick(1);
    any_pass |= ped_if.pass_request;
    check("t5_served", 32'(ped_if.served), 32'd1);
    tick(1);
    any_pass |= ped_if.pass_request;
    check("t5_served_pulse", 32'(ped_if.served), 32'd0);
    check("t5_wait_serving", 32'(ped_if.wait_led), 32'd1);
    check("t5_never_pass", 32'(any_pass), 32'd0);
    ped_if.btn_raw = 1'b0;

    // 6: asynchronous reset while requesting
    do_reset();
    ped_if.green   = 1'b1;
    ped_if.clock   = 8'd50;
    ped_if.btn_raw = 1'b1;
    tick(20);
    check("t6_pass_before", 32'(ped_if.pass_request), 32'd1);
    rst            = 1'b1;
    ped_if.btn_raw = 1'b0;
    #1;
    check("t6_pass_async", 32'(ped_if.pass_request), 32'd0);
    check("t6_wait_async", 32'(ped_if.wait_led), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    check("t6_pass_after", 32'(ped_if.pass_request), 32'd0);
    check("t6_wait_after", 32'(ped_if.wait_led), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
